seq_counter: RTL and testbench

Timing-state sequence counter for the multicycle processor control unit. It drives the 4-bit input of the registered 4-to-16 timing decoder, which turns the count into the one-hot T0..T15 timing signals. It counts one step per clock while an instruction executes, clears at end of instruction, and stops on halt. A small run-control state machine and an error flag sit around the counter.

---
 rtl/seq_counter_if.sv | 30 +++
 rtl/seq_counter.sv | 84 ++++++++
 tb/tb_seq_counter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_counter_if.sv
// Control and status bundle for seq_counter. The optional stall input exists
// only when SEQ_CNT_STALL_EN is defined.
interface seq_counter_if;
  // start/clr/hlt/stall are level-sampled on every rising edge with no
  // handshake back. sc/running/instr_done/ovr_err are registered and valid
  // after the edge. state is a read-only debug view of the run-control FSM.
  logic       start;
  logic       clr;
  logic       hlt;
`ifdef SEQ_CNT_STALL_EN
  logic       stall;
`endif
  logic [3:0] sc;
  logic       running;
  logic       instr_done;
  logic       ovr_err;
  logic [1:0] state;

`ifdef SEQ_CNT_STALL_EN
  modport master (output start, clr, hlt, stall,
                  input  sc, running, instr_done, ovr_err, state);
  modport slave  (input  start, clr, hlt, stall,
                  output sc, running, instr_done, ovr_err, state);
`else
  modport master (output start, clr, hlt,
                  input  sc, running, instr_done, ovr_err, state);
  modport slave  (input  start, clr, hlt,
                  output sc, running, instr_done, ovr_err, state);
`endif
endinterface

// File: rtl/seq_counter.sv
// Timing-state sequence counter with IDLE/RUN/HALT run control and a sticky overrun flag.
// Optional count freeze input is built in when SEQ_CNT_STALL_EN is defined.
module seq_counter #(
  parameter int unsigned MAX_T = 15
) (
  input logic          clk,
  input logic          rst_n,
  seq_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] MaxT = 4'(MAX_T);

  state_t     state_q;
  logic [3:0] sc_q;
  logic       running_q;
  logic       instr_done_q;
  logic       ovr_err_q;

  logic       stall_w;
`ifdef SEQ_CNT_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sc_q         <= 4'd0;
      running_q    <= 1'b0;
      instr_done_q <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      instr_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALT: begin
          sc_q      <= 4'd0;
          running_q <= 1'b0;
          if (bus.start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            ovr_err_q <= 1'b0;
          end
        end
        ST_RUN: begin
          // hlt beats clr beats stall beats the overrun wrap.
          if (bus.hlt) begin
            state_q   <= ST_HALT;
            running_q <= 1'b0;
            sc_q      <= 4'd0;
          end else if (bus.clr) begin
            sc_q         <= 4'd0;
            instr_done_q <= 1'b1;
          end else if (stall_w) begin
            sc_q <= sc_q;
          end else if (sc_q == MaxT) begin
            sc_q      <= 4'd0;
            ovr_err_q <= 1'b1;
          end else begin
            sc_q <= sc_q + 4'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          sc_q      <= 4'd0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sc         = sc_q;
  assign bus.running    = running_q;
  assign bus.instr_done = instr_done_q;
  assign bus.ovr_err    = ovr_err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter: one instance with MAX_T=5, one with the default MAX_T=15.
module tb_seq_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic start_r, clr_r, hlt_r, stall_r;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_counter_if if5 ();
  seq_counter_if if15 ();

  assign if5.start  = start_r;
  assign if5.clr    = clr_r;
  assign if5.hlt    = hlt_r;
  assign if15.start = start_r;
  assign if15.clr   = clr_r;
  assign if15.hlt   = hlt_r;
`ifdef SEQ_CNT_STALL_EN
  assign if5.stall  = stall_r;
  assign if15.stall = stall_r;
`endif

  seq_counter #(.MAX_T(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
  seq_counter              dut15 (.clk(clk), .rst_n(rst_n), .bus(if15.slave));

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_r = 1'b0;
    start_r = 1'($urandom_range(0, 1)); clr_r = 1'($urandom_range(0, 1)); hlt_r = 1'($urandom_range(0, 1));
    tick();
    start_r = 1'b1; clr_r = 1'($urandom_range(0, 1)); hlt_r = 1'($urandom_range(0, 1));
    tick();
    total++; if (if5.sc !== 4'd0) begin bad++; $display("FAIL reset_sc got=%0d exp=0", if5.sc); end
    total++; if (if5.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", if5.running); end
    total++; if (if5.ovr_err !== 1'b0 || if5.instr_done !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", if5.ovr_err, if5.instr_done); end
    total++; if (if15.state !== S_IDLE || if15.sc !== 4'd0) begin bad++; $display("FAIL reset_15 got=%0d/%0d exp=0/0", if15.state, if15.sc); end
    rst_n = 1'b1; start_r = 1'b0; clr_r = 1'b0; hlt_r = 1'b0;
    tick();
    total++; if (if5.state !== S_IDLE || if5.running !== 1'b0) begin bad++; $display("FAIL reset_start_lost got=%0d/%b exp=0/0", if5.state, if5.running); end
    clr_r = 1'b1; hlt_r = 1'b1;
    tick();
    total++; if (if5.state !== S_IDLE || if5.instr_done !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%0d/%b exp=0/0", if5.state, if5.instr_done); end
    clr_r = 1'b0; hlt_r = 1'b0;
  endtask

  task automatic test_start();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    total++; if (if5.running !== 1'b1 || if5.sc !== 4'd0 || if5.state !== S_RUN) begin bad++; $display("FAIL start got=%b/%0d/%0d exp=1/0/1", if5.running, if5.sc, if5.state); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (if5.sc !== 4'(i)) begin bad++; $display("FAIL count got=%0d exp=%0d", if5.sc, i); end
    end
  endtask

  task automatic test_clr();
    clr_r = 1'b1;
    tick();
    clr_r = 1'b0;
    total++; if (if5.sc !== 4'd0 || if5.instr_done !== 1'b1) begin bad++; $display("FAIL clr got=%0d/%b exp=0/1", if5.sc, if5.instr_done); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (if5.sc !== 4'(i) || if5.instr_done !== 1'b0) begin bad++; $display("FAIL after_clr got=%0d/%b exp=%0d/0", if5.sc, if5.instr_done, i); end
    end
  endtask

  task automatic test_overrun();
    for (int i = 3; i <= 5; i++) begin
      tick();
      total++; if (if5.sc !== 4'(i) || if5.ovr_err !== 1'b0) begin bad++; $display("FAIL ovr_ramp got=%0d/%b exp=%0d/0", if5.sc, if5.ovr_err, i); end
    end
    tick();
    total++; if (if5.sc !== 4'd0 || if5.ovr_err !== 1'b1) begin bad++; $display("FAIL ovr_wrap got=%0d/%b exp=0/1", if5.sc, if5.ovr_err); end
    tick();
    total++; if (if5.sc !== 4'd1 || if5.ovr_err !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0d/%b exp=1/1", if5.sc, if5.ovr_err); end
  endtask

  task automatic test_simultaneous();
    tick();
    hlt_r = 1'b1; clr_r = 1'b1;
    tick();
    hlt_r = 1'b0; clr_r = 1'b0;
    total++; if (if5.state !== S_HALT || if5.sc !== 4'd0 || if5.instr_done !== 1'b0 || if5.running !== 1'b0) begin bad++; $display("FAIL hlt_clr got=%0d/%0d/%b exp=2/0/0", if5.state, if5.sc, if5.instr_done); end
    total++; if (if5.ovr_err !== 1'b1) begin bad++; $display("FAIL ovr_in_halt got=%b exp=1", if5.ovr_err); end
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    total++; if (if5.running !== 1'b1 || if5.sc !== 4'd0 || if5.ovr_err !== 1'b0) begin bad++; $display("FAIL restart_ovr got=%b/%0d/%b exp=1/0/0", if5.running, if5.sc, if5.ovr_err); end
    repeat (5) tick();
    total++; if (if5.sc !== 4'd5) begin bad++; $display("FAIL reach_max got=%0d exp=5", if5.sc); end
    clr_r = 1'b1;
    tick();
    clr_r = 1'b0;
    total++; if (if5.sc !== 4'd0 || if5.instr_done !== 1'b1 || if5.ovr_err !== 1'b0) begin bad++; $display("FAIL clr_at_max got=%0d/%b/%b exp=0/1/0", if5.sc, if5.instr_done, if5.ovr_err); end
  endtask

  task automatic test_halt_restart();
    repeat (4) tick();
    total++; if (if5.sc !== 4'd4) begin bad++; $display("FAIL pre_halt got=%0d exp=4", if5.sc); end
    hlt_r = 1'b1;
    tick();
    hlt_r = 1'b0; clr_r = 1'b1;
    total++; if (if5.sc !== 4'd0 || if5.running !== 1'b0) begin bad++; $display("FAIL halt got=%0d/%b exp=0/0", if5.sc, if5.running); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (if5.sc !== 4'd0 || if5.running !== 1'b0 || if5.instr_done !== 1'b0) begin bad++; $display("FAIL halt_hold got=%0d/%b/%b exp=0/0/0", if5.sc, if5.running, if5.instr_done); end
    end
    clr_r = 1'b0; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    total++; if (if5.running !== 1'b1 || if5.sc !== 4'd0) begin bad++; $display("FAIL halt_restart got=%b/%0d exp=1/0", if5.running, if5.sc); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (if5.sc !== 4'(i)) begin bad++; $display("FAIL restart_count got=%0d exp=%0d", if5.sc, i); end
    end
  endtask

  task automatic test_start_in_run();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    total++; if (if5.sc !== 4'd3 || if5.state !== S_RUN) begin bad++; $display("FAIL start_in_run got=%0d/%0d exp=3/1", if5.sc, if5.state); end
  endtask

  task automatic test_full_wrap();
    hlt_r = 1'b1;
    tick();
    hlt_r = 1'b0; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    total++; if (if15.sc !== 4'd0 || if15.running !== 1'b1) begin bad++; $display("FAIL w15_start got=%0d/%b exp=0/1", if15.sc, if15.running); end
    repeat (15) tick();
    total++; if (if15.sc !== 4'd15 || if15.ovr_err !== 1'b0) begin bad++; $display("FAIL w15_max got=%0d/%b exp=15/0", if15.sc, if15.ovr_err); end
    tick();
    total++; if (if15.sc !== 4'd0 || if15.ovr_err !== 1'b1) begin bad++; $display("FAIL w15_wrap got=%0d/%b exp=0/1", if15.sc, if15.ovr_err); end
  endtask

  task automatic test_reset_mid();
    repeat (2) tick();
    rst_n = 1'b0; hlt_r = 1'b1; clr_r = 1'b1; start_r = 1'b1;
    tick();
    rst_n = 1'b1; hlt_r = 1'b0; clr_r = 1'b0; start_r = 1'b0;
    total++; if (if15.sc !== 4'd0 || if15.running !== 1'b0 || if15.ovr_err !== 1'b0 || if15.state !== S_IDLE) begin bad++; $display("FAIL reset_mid got=%0d/%b/%b/%0d exp=0/0/0/0", if15.sc, if15.running, if15.ovr_err, if15.state); end
  endtask

`ifdef SEQ_CNT_STALL_EN
  task automatic test_stall();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (6) tick();
    stall_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if15.sc !== 4'd6) begin bad++; $display("FAIL stall_hold got=%0d exp=6", if15.sc); end
    end
    stall_r = 1'b0;
    repeat (9) tick();
    stall_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (if15.sc !== 4'd15 || if15.ovr_err !== 1'b0) begin bad++; $display("FAIL stall_max got=%0d/%b exp=15/0", if15.sc, if15.ovr_err); end
    end
    clr_r = 1'b1;
    tick();
    clr_r = 1'b0; stall_r = 1'b0;
    total++; if (if15.sc !== 4'd0 || if15.instr_done !== 1'b1) begin bad++; $display("FAIL stall_clr got=%0d/%b exp=0/1", if15.sc, if15.instr_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_clr();
    test_overrun();
    test_simultaneous();
    test_halt_restart();
    test_start_in_run();
    test_full_wrap();
    test_reset_mid();
`ifdef SEQ_CNT_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
